// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_pkg
// Description : Shared constants and types for the accumulator processor
//               control unit: word/opcode widths, opcode encodings, the
//               sequencer state encoding and the bundle of control strobes.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_pkg;

  // System word and instruction field widths
  localparam int WORD_W = 8;
  localparam int OP_W   = 3;
  localparam int ADDR_W = WORD_W - OP_W;

  // Opcode encodings; 3'b101..3'b111 are undefined and execute as NOP
  localparam logic [OP_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OP_W-1:0] OP_STORE = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD   = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB   = 3'b011;
  localparam logic [OP_W-1:0] OP_BNE   = 3'b100;

  // Sequencer states: reset, three fetch cycles, decode, two execute
  // cycles and the bus-hold state granted to an external master
  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_F0   = 3'd1,
    ST_F1   = 3'd2,
    ST_F2   = 3'd3,
    ST_D0   = 3'd4,
    ST_E0   = 3'd5,
    ST_E1   = 3'd6,
    ST_HOLD = 3'd7
  } state_t;

  // Every strobe the sequencer drives, gathered so a state can start from
  // an all-idle word and raise only what it needs
  typedef struct packed {
    logic hold_ack;
    logic acc_bus;
    logic load_acc;
    logic pc_bus;
    logic load_pc;
    logic inc_pc;
    logic load_ir;
    logic addr_bus;
    logic load_mar;
    logic mdr_bus;
    logic load_mdr;
    logic cs;
    logic r_nw;
    logic alu_acc;
    logic alu_add;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // True for the opcodes that need an operand cycle through RAM
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_ADD)  || (op == OP_SUB);
  endfunction

endpackage : proc_pkg
`default_nettype wire

// File: rtl/proc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : proc_sequencer
// Description : Moore control unit for the 8-bit accumulator processor.
//               Steps each instruction through fetch/decode/execute, drives
//               the sysbus enables and load strobes, and hands the sysbus to
//               an external master at instruction boundaries through a
//               hold_req/hold_ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_sequencer
  import proc_pkg::*;
(
  input  logic            clock,
  input  logic            n_reset,
  input  logic [OP_W-1:0] op,
  input  logic            z_flag,
  input  logic            hold_req,
  output logic            hold_ack,
  output logic            ACC_bus,
  output logic            load_ACC,
  output logic            PC_bus,
  output logic            load_PC,
  output logic            INC_PC,
  output logic            load_IR,
  output logic            Addr_bus,
  output logic            load_MAR,
  output logic            MDR_bus,
  output logic            load_MDR,
  output logic            CS,
  output logic            R_NW,
  output logic            ALU_ACC,
  output logic            ALU_add
);

  state_t state_q;
  state_t state_d;
  state_t boundary_state;
  ctrl_t  ctrl;

  // State register; reset aborts any instruction at once, so every strobe
  // (including a RAM write in progress) drops without waiting for a clock
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; hold_req is only looked at where an instruction ends
  always_comb begin
    boundary_state = hold_req ? ST_HOLD : ST_F0;
    state_d        = state_q;
    case (state_q)
      ST_RST:  state_d = boundary_state;
      ST_F0:   state_d = ST_F1;
      ST_F1:   state_d = ST_F2;
      ST_F2:   state_d = ST_D0;
      // BNE and undefined opcodes complete in decode; memory ops continue
      ST_D0:   state_d = is_mem_op(op) ? ST_E0 : boundary_state;
      ST_E0:   state_d = ST_E1;
      ST_E1:   state_d = boundary_state;
      // Release restarts fetch at the current PC one cycle later
      ST_HOLD: state_d = hold_req ? ST_HOLD : ST_F0;
      default: state_d = ST_RST;
    endcase
  end

  // Output decode from the registered state, with op/z_flag refining the
  // decode and execute cycles; at most one bus driver per state
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state_q)
      ST_F0: begin
        // Current PC onto the bus as the fetch address
        ctrl.pc_bus   = 1'b1;
        ctrl.load_mar = 1'b1;
      end
      ST_F1: begin
        // RAM read of the instruction; PC advances in the same cycle
        ctrl.cs     = 1'b1;
        ctrl.r_nw   = 1'b1;
        ctrl.inc_pc = 1'b1;
      end
      ST_F2: begin
        ctrl.mdr_bus = 1'b1;
        ctrl.load_ir = 1'b1;
      end
      ST_D0: begin
        if (op == OP_BNE) begin
          // Branch taken only when the accumulator is non-zero
          if (!z_flag) begin
            ctrl.addr_bus = 1'b1;
            ctrl.load_pc  = 1'b1;
          end
        end else if (is_mem_op(op)) begin
          // Operand address from the IR into the MAR
          ctrl.addr_bus = 1'b1;
          ctrl.load_mar = 1'b1;
        end
      end
      ST_E0: begin
        if (op == OP_STORE) begin
          ctrl.acc_bus  = 1'b1;
          ctrl.load_mdr = 1'b1;
        end else if (is_mem_op(op)) begin
          ctrl.cs   = 1'b1;
          ctrl.r_nw = 1'b1;
        end
      end
      ST_E1: begin
        case (op)
          OP_LOAD: begin
            ctrl.mdr_bus  = 1'b1;
            ctrl.alu_acc  = 1'b1;
            ctrl.load_acc = 1'b1;
          end
          OP_ADD: begin
            ctrl.mdr_bus  = 1'b1;
            ctrl.alu_add  = 1'b1;
            ctrl.load_acc = 1'b1;
          end
          OP_SUB: begin
            // ALU_ACC=0 with ALU_add=0 selects subtract
            ctrl.mdr_bus  = 1'b1;
            ctrl.load_acc = 1'b1;
          end
          OP_STORE: begin
            // R_NW stays 0: this is the write cycle
            ctrl.cs = 1'b1;
          end
          default: ctrl = CTRL_IDLE;
        endcase
      end
      ST_HOLD: ctrl.hold_ack = 1'b1;
      default: ctrl = CTRL_IDLE;
    endcase
  end

  assign hold_ack = ctrl.hold_ack;
  assign ACC_bus  = ctrl.acc_bus;
  assign load_ACC = ctrl.load_acc;
  assign PC_bus   = ctrl.pc_bus;
  assign load_PC  = ctrl.load_pc;
  assign INC_PC   = ctrl.inc_pc;
  assign load_IR  = ctrl.load_ir;
  assign Addr_bus = ctrl.addr_bus;
  assign load_MAR = ctrl.load_mar;
  assign MDR_bus  = ctrl.mdr_bus;
  assign load_MDR = ctrl.load_mdr;
  assign CS       = ctrl.cs;
  assign R_NW     = ctrl.r_nw;
  assign ALU_ACC  = ctrl.alu_acc;
  assign ALU_add  = ctrl.alu_add;

endmodule : proc_sequencer
`default_nettype wire

// File: tb/tb_proc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_sequencer
// Description : Directed bench for proc_sequencer, wired to a small model of
//               the accumulator datapath (PC, IR, ACC, MAR/MDR, 32-word RAM)
//               so a real program runs through the control unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_sequencer;
  import proc_pkg::*;

  logic            clock = 1'b0;
  logic            n_reset;
  logic [OP_W-1:0] op;
  logic            z_flag;
  logic            hold_req;
  logic hold_ack, ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR;
  logic Addr_bus, load_MAR, MDR_bus, load_MDR, CS, R_NW, ALU_ACC, ALU_add;

  always #5 clock = ~clock;

  proc_sequencer dut (
    .clock(clock), .n_reset(n_reset), .op(op), .z_flag(z_flag),
    .hold_req(hold_req), .hold_ack(hold_ack), .ACC_bus(ACC_bus),
    .load_ACC(load_ACC), .PC_bus(PC_bus), .load_PC(load_PC),
    .INC_PC(INC_PC), .load_IR(load_IR), .Addr_bus(Addr_bus),
    .load_MAR(load_MAR), .MDR_bus(MDR_bus), .load_MDR(load_MDR),
    .CS(CS), .R_NW(R_NW), .ALU_ACC(ALU_ACC), .ALU_add(ALU_add)
  );

  // Strobe word, MSB first: hold_ack ACC_bus load_ACC PC_bus load_PC INC_PC
  // load_IR Addr_bus load_MAR MDR_bus load_MDR CS R_NW ALU_ACC ALU_add
  logic [14:0] ctl;
  assign ctl = {hold_ack, ACC_bus, load_ACC, PC_bus, load_PC, INC_PC, load_IR,
                Addr_bus, load_MAR, MDR_bus, load_MDR, CS, R_NW, ALU_ACC, ALU_add};

  localparam logic [14:0] B_HACK = 15'h4000, B_ACCB = 15'h2000, B_LACC = 15'h1000;
  localparam logic [14:0] B_PCB  = 15'h0800, B_LPC  = 15'h0400, B_INC  = 15'h0200;
  localparam logic [14:0] B_LIR  = 15'h0100, B_ADB  = 15'h0080, B_LMAR = 15'h0040;
  localparam logic [14:0] B_MDRB = 15'h0020, B_LMDR = 15'h0010, B_CS   = 15'h0008;
  localparam logic [14:0] B_RNW  = 15'h0004, B_AACC = 15'h0002, B_AADD = 15'h0001;

  localparam logic [14:0] C_F0   = B_PCB  | B_LMAR;
  localparam logic [14:0] C_F1   = B_CS   | B_RNW | B_INC;
  localparam logic [14:0] C_F2   = B_MDRB | B_LIR;
  localparam logic [14:0] C_DMEM = B_ADB  | B_LMAR;
  localparam logic [14:0] C_RD   = B_CS   | B_RNW;
  localparam logic [14:0] C_LD   = B_MDRB | B_AACC | B_LACC;
  localparam logic [14:0] C_ADD  = B_MDRB | B_AADD | B_LACC;
  localparam logic [14:0] C_SUB  = B_MDRB | B_LACC;
  localparam logic [14:0] C_STE0 = B_ACCB | B_LMDR;
  localparam logic [14:0] C_WR   = B_CS;
  localparam logic [14:0] C_BNE  = B_ADB  | B_LPC;
  localparam logic [14:0] C_HOLD = B_HACK;

  // ---------------- datapath model ----------------
  logic [7:0] mem [0:31];
  logic [4:0] pc, mar;
  logic [7:0] ir, acc, mdr, bus;
  logic       load_prog;

  function automatic logic [7:0] prog(input int a);
    case (a)
      0:  return 8'h04;  // LOAD 4
      1:  return 8'h45;  // ADD 5
      2:  return 8'h26;  // STORE 6
      3:  return 8'h87;  // BNE 7
      4:  return 8'h02;
      5:  return 8'h02;
      7:  return 8'hE0;  // undefined opcode 111
      8:  return 8'h64;  // SUB 4
      9:  return 8'h65;  // SUB 5
      10: return 8'h80;  // BNE 0
      11: return 8'h26;  // STORE 6
      default: return 8'h00;
    endcase
  endfunction

  assign bus = PC_bus   ? {3'b000, pc}      :
               Addr_bus ? {3'b000, ir[4:0]} :
               MDR_bus  ? mdr               :
               ACC_bus  ? acc               : 8'h00;
  assign op     = ir[7:5];
  assign z_flag = (acc == 8'h00);

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      pc <= '0; mar <= '0; ir <= '0; acc <= '0; mdr <= '0;
      if (load_prog) for (int i = 0; i < 32; i++) mem[i] <= prog(i);
    end else begin
      if (load_PC) pc <= bus[4:0];
      else if (INC_PC) pc <= pc + 5'd1;
      if (load_IR) ir <= bus;
      if (load_MAR) mar <= bus[4:0];
      if (load_MDR) mdr <= bus;
      else if (CS && R_NW) mdr <= mem[mar];
      if (load_ACC) acc <= ALU_ACC ? bus : (ALU_add ? acc + bus : acc - bus);
      if (CS && !R_NW) mem[mar] <= mdr;
    end
  end

  // ---------------- checking ----------------
  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Checks F0/F1/F2 of the current instruction and leaves the bench in D0
  task automatic fetch_chk(input string tag);
    check({tag, "_f0"}, ctl, C_F0); step();
    check({tag, "_f1"}, ctl, C_F1); step();
    check({tag, "_f2"}, ctl, C_F2); step();
  endtask

  // Bus-driver exclusivity and a quiet bus while held, every cycle
  always @(negedge clock) begin
    if (n_reset === 1'b1) begin
      check("one_driver", ($countones({ACC_bus, PC_bus, Addr_bus, MDR_bus}) <= 1), 1);
      check("hold_quiet", hold_ack ? ctl[13:0] : 14'h0, 14'h0);
    end
  end

  initial begin
    hold_req  = 1'b0;
    load_prog = 1'b1;
    n_reset   = 1'b1;
    #1 n_reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_ctl", ctl, 15'h0);
    check("rst_state", dut.state_q, ST_RST);
    n_reset   = 1'b1;
    load_prog = 1'b0;
    check("rst_rel_ctl", ctl, 15'h0);
    step();

    // LOAD 4
    fetch_chk("load");
    check("load_d0", ctl, C_DMEM); step();
    check("load_e0", ctl, C_RD);   step();
    check("load_e1", ctl, C_LD);   step();
    check("acc_load", acc, 8'd2);
    // ADD 5
    fetch_chk("add");
    check("add_d0", ctl, C_DMEM); step();
    check("add_e0", ctl, C_RD);   step();
    check("add_e1", ctl, C_ADD);  step();
    check("acc_add", acc, 8'd4);
    // STORE 6: write lands at the end of cycle 19
    fetch_chk("store");
    check("store_d0", ctl, C_DMEM); step();
    check("store_e0", ctl, C_STE0); step();
    check("store_e1", ctl, C_WR);   step();
    check("mem6_store", mem[6], 8'd4);
    // BNE 7 taken (ACC=4)
    fetch_chk("bne_t");
    check("bne_t_d0", ctl, C_BNE); step();
    check("bne_t_f0", ctl, C_F0);
    check("bne_t_pc", pc, 5'd7);
    // Undefined opcode 111 is a 4-cycle NOP
    fetch_chk("nop");
    check("nop_d0", ctl, 15'h0); step();
    check("nop_next_f0", ctl, C_F0);
    check("nop_pc", pc, 5'd8);
    // SUB 4 then SUB 5: ACC 4 -> 2 -> 0
    fetch_chk("sub1");
    step(); step();
    check("sub1_e1", ctl, C_SUB); step();
    check("acc_sub1", acc, 8'd2);
    fetch_chk("sub2");
    step(); step(); step();
    check("acc_sub2", acc, 8'd0);
    // BNE 0 not taken (ACC=0)
    fetch_chk("bne_nt");
    check("bne_nt_d0", ctl, 15'h0); step();
    check("bne_nt_f0", ctl, C_F0);
    check("bne_nt_pc", pc, 5'd11);
    // STORE 6 aborted by reset in its write cycle
    fetch_chk("store2");
    step(); step();
    check("store2_e1", ctl, C_WR);
    #2 n_reset = 1'b0;
    #1;
    check("abort_cs", CS, 1'b0);
    check("abort_ctl", ctl, 15'h0);
    check("abort_state", dut.state_q, ST_RST);
    step();
    check("mem6_kept", mem[6], 8'd4);
    n_reset = 1'b1;
    step();

    // Hold requested during E0 of an ADD
    fetch_chk("load2");
    step(); step(); step();
    fetch_chk("add2");
    step();
    hold_req = 1'b1;
    check("add2_e0", ctl, C_RD); step();
    check("add2_e1_hold", ctl, C_ADD); step();
    check("hold_grant", ctl, C_HOLD); step();
    check("hold_stay", ctl, C_HOLD);
    check("acc_add2", acc, 8'd4);
    hold_req = 1'b0;
    step();
    check("release_f0", ctl, C_F0);
    check("release_pc", pc, 5'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_proc_sequencer
`default_nettype wire
